// File: rtl/hsi_s_rx_ctrl_pkg.sv
// Shared constants for the HSI slave receive path: frame type bytes,
// one-hot message indices, error codes and CRC16-CCITT parameters.
package hsi_pkg;

  // Frame type bytes as they appear first on the wire
  localparam logic [7:0] HSI_TYPE_TM  = 8'hA1;
  localparam logic [7:0] HSI_TYPE_BTC = 8'hA2;
  localparam logic [7:0] HSI_TYPE_SR  = 8'hA3;
  localparam logic [7:0] HSI_TYPE_DPR = 8'hA4;
  localparam logic [7:0] HSI_TYPE_CCW = 8'hA5;

  // Bit positions inside the one-hot msg_type vector
  localparam int HSI_IDX_TM  = 0;
  localparam int HSI_IDX_BTC = 1;
  localparam int HSI_IDX_SR  = 2;
  localparam int HSI_IDX_DPR = 3;
  localparam int HSI_IDX_CCW = 4;

  // err_code values reported alongside msg_err
  localparam logic [1:0] HSI_ERR_NONE = 2'd0;
  localparam logic [1:0] HSI_ERR_UNK  = 2'd1;
  localparam logic [1:0] HSI_ERR_CRC  = 2'd2;
  localparam logic [1:0] HSI_ERR_GAP  = 2'd3;

  // CRC16-CCITT, MSB-first, no reflection, no final XOR
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Receive framing states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PAYLOAD,
    RX_CRC_HI,
    RX_CRC_LO
  } rx_state_e;

  // Map a type byte to its one-hot message type; all zeros means unknown
  function automatic logic [4:0] hsi_type_onehot(input logic [7:0] b);
    logic [4:0] oh;
    oh = '0;
    case (b)
      HSI_TYPE_TM:  oh[HSI_IDX_TM]  = 1'b1;
      HSI_TYPE_BTC: oh[HSI_IDX_BTC] = 1'b1;
      HSI_TYPE_SR:  oh[HSI_IDX_SR]  = 1'b1;
      HSI_TYPE_DPR: oh[HSI_IDX_DPR] = 1'b1;
      HSI_TYPE_CCW: oh[HSI_IDX_CCW] = 1'b1;
      default:      oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/hsi_s_rx_ctrl_if.sv
// Byte-stream input and message/status outputs of the HSI slave receiver.
// The master modport is the side feeding decoded bytes and consuming the
// framed results; the slave modport is the receive controller itself.
interface hsi_s_rx_ctrl_if;

  logic [7:0]  d;
  logic        d_rdy;
  logic [7:0]  q;
  logic        q_rdy;
  logic [4:0]  msg_type;
  logic        msg_start;
  logic        msg_ok;
  logic        msg_err;
  logic [1:0]  err_code;
  logic [39:0] btc;
  logic        rx_busy;

  modport master (
    output d, d_rdy,
    input  q, q_rdy, msg_type, msg_start, msg_ok, msg_err, err_code, btc, rx_busy
  );

  modport slave (
    input  d, d_rdy,
    output q, q_rdy, msg_type, msg_start, msg_ok, msg_err, err_code, btc, rx_busy
  );

endinterface

// File: rtl/hsi_rx_crc16.sv
// Registered byte-wise CRC16-CCITT. init reseeds the register, en folds
// `data` in; with both high the byte is folded into a fresh seed so the
// type byte can open a frame in a single cycle. crc_next exposes the value
// the register is about to take so the caller can judge the final byte
// in the same cycle it arrives.
module hsi_rx_crc16
  import hsi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  logic [15:0] crc_reg;
  logic [15:0] seed;
  logic [15:0] crc_upd;

  assign seed = init ? CRC_INIT : crc_reg;

  // Fold one byte into the running CRC, most significant bit first
  always_comb begin
    crc_upd = seed ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      crc_upd = crc_upd[15] ? ((crc_upd << 1) ^ CRC_POLY) : (crc_upd << 1);
    end
  end

  // Select the value the register takes this cycle
  always_comb begin
    crc_next = crc_reg;
    if (en) begin
      crc_next = crc_upd;
    end else if (init) begin
      crc_next = CRC_INIT;
    end
  end

  // CRC register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= '0;
    end else begin
      crc_reg <= crc_next;
    end
  end

endmodule

// File: rtl/hsi_s_rx_ctrl.sv
// HSI slave receive controller: frames the decoded byte stream into
// TM/BTC/SR/DPR/CCW messages, checks the trailing CRC16, forwards payload,
// latches the BTC value and reports framing, CRC and gap errors.
module hsi_s_rx_ctrl
  import hsi_pkg::*;
#(
  parameter int TM_LEN     = 32,
  parameter int CCW_LEN    = 4,
  parameter int GAP_CYCLES = 4000
)
(
  input  logic            clk,
  input  logic            rst,
  hsi_s_rx_ctrl_if.slave  bus
);

  // gap_reg is zero in the first cycle after a byte, so it reads
  // GAP_CYCLES-2 in the cycle GAP_CYCLES-1 after the byte; expiring there
  // lands the registered error exactly GAP_CYCLES cycles after that byte.
  localparam int              GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

  rx_state_e          state_reg, state_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [39:0]        shadow_reg, shadow_next;
  logic [39:0]        btc_reg, btc_next;
  logic [7:0]         q_reg, q_next;
  logic               q_rdy_reg, q_rdy_next;
  logic [4:0]         type_reg, type_next;
  logic               start_reg, start_next;
  logic               ok_reg, ok_next;
  logic               err_reg, err_next;
  logic [1:0]         code_reg, code_next;
  logic               busy_reg, busy_next;

  logic               crc_init;
  logic               crc_en;
  logic [15:0]        crc_next;
  logic [4:0]         d_onehot;
  logic [7:0]         d_len;
  logic               gap_expire;

  hsi_rx_crc16 u_crc (
    .clk      (clk),
    .rst      (rst),
    .init     (crc_init),
    .en       (crc_en),
    .data     (bus.d),
    .crc_next (crc_next)
  );

  // Decode the incoming byte as a type byte and look up its payload length
  always_comb begin
    d_onehot = hsi_type_onehot(bus.d);
    d_len    = 8'd0;
    if (d_onehot[HSI_IDX_TM]) begin
      d_len = 8'(TM_LEN);
    end else if (d_onehot[HSI_IDX_BTC]) begin
      d_len = 8'd5;
    end else if (d_onehot[HSI_IDX_CCW]) begin
      d_len = 8'(CCW_LEN);
    end
  end

  assign gap_expire = (state_reg != RX_IDLE) && !bus.d_rdy && (gap_reg == GAP_LAST);

  // Next-state and registered-output logic; a byte always beats the timeout
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shadow_next = shadow_reg;
    btc_next    = btc_reg;
    q_next      = q_reg;
    type_next   = type_reg;
    code_next   = code_reg;
    q_rdy_next  = 1'b0;
    start_next  = 1'b0;
    ok_next     = 1'b0;
    err_next    = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;

    case (state_reg)
      RX_IDLE: begin
        if (bus.d_rdy) begin
          if (d_onehot != 5'd0) begin
            type_next  = d_onehot;
            start_next = 1'b1;
            crc_init   = 1'b1;
            crc_en     = 1'b1;
            cnt_next   = d_len;
            state_next = (d_len == 8'd0) ? RX_CRC_HI : RX_PAYLOAD;
          end else begin
            err_next  = 1'b1;
            code_next = HSI_ERR_UNK;
          end
        end
      end
      RX_PAYLOAD: begin
        if (bus.d_rdy) begin
          crc_en     = 1'b1;
          q_next     = bus.d;
          q_rdy_next = 1'b1;
          if (type_reg[HSI_IDX_BTC]) begin
            shadow_next = {shadow_reg[31:0], bus.d};
          end
          cnt_next = cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) begin
            state_next = RX_CRC_HI;
          end
        end
      end
      RX_CRC_HI: begin
        if (bus.d_rdy) begin
          crc_en     = 1'b1;
          state_next = RX_CRC_LO;
        end
      end
      RX_CRC_LO: begin
        if (bus.d_rdy) begin
          crc_en     = 1'b1;
          state_next = RX_IDLE;
          if (crc_next == 16'h0000) begin
            ok_next = 1'b1;
            if (type_reg[HSI_IDX_BTC]) begin
              btc_next = shadow_reg;
            end
          end else begin
            err_next  = 1'b1;
            code_next = HSI_ERR_CRC;
          end
        end
      end
      default: state_next = RX_IDLE;
    endcase

    if (gap_expire) begin
      state_next = RX_IDLE;
      err_next   = 1'b1;
      code_next  = HSI_ERR_GAP;
    end

    busy_next = (state_next != RX_IDLE);
    gap_next  = (bus.d_rdy || state_reg == RX_IDLE) ? '0 : gap_reg + GAP_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counters, shadow register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      gap_reg    <= '0;
      shadow_reg <= '0;
      btc_reg    <= '0;
      q_reg      <= '0;
      q_rdy_reg  <= 1'b0;
      type_reg   <= '0;
      start_reg  <= 1'b0;
      ok_reg     <= 1'b0;
      err_reg    <= 1'b0;
      code_reg   <= HSI_ERR_NONE;
      busy_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      gap_reg    <= gap_next;
      shadow_reg <= shadow_next;
      btc_reg    <= btc_next;
      q_reg      <= q_next;
      q_rdy_reg  <= q_rdy_next;
      type_reg   <= type_next;
      start_reg  <= start_next;
      ok_reg     <= ok_next;
      err_reg    <= err_next;
      code_reg   <= code_next;
      busy_reg   <= busy_next;
    end
  end

  assign bus.q         = q_reg;
  assign bus.q_rdy     = q_rdy_reg;
  assign bus.msg_type  = type_reg;
  assign bus.msg_start = start_reg;
  assign bus.msg_ok    = ok_reg;
  assign bus.msg_err   = err_reg;
  assign bus.err_code  = code_reg;
  assign bus.btc       = btc_reg;
  assign bus.rx_busy   = busy_reg;

endmodule

// File: tb/tb_hsi_s_rx_ctrl.sv
// Bench for hsi_s_rx_ctrl: directed frames plus a randomized frame mix.
// Every driven byte is logged with its cycle; a frame-level model turns
// that log into the expected event list, which is compared with the
// events observed on the outputs.
module tb_hsi_s_rx_ctrl;

  localparam int TM_LEN  = 32;
  localparam int CCW_LEN = 4;
  localparam int GAP     = 4000;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          cyc;
    int          kind;   // 0 q_rdy, 1 msg_start, 2 msg_ok, 3 msg_err
    logic [39:0] val;
    logic [4:0]  mt;
    logic [39:0] btc;
  } ev_t;
  typedef struct {
    logic [7:0] b;
    int         cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  hsi_s_rx_ctrl_if bus();

  hsi_s_rx_ctrl #(
    .TM_LEN     (TM_LEN),
    .CCW_LEN    (CCW_LEN),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t obs_q[$];
  ev_t exp_q[$];
  sb_t stream[$];
  int  busy_cnt = 0;
  int  both_cnt = 0;
  int  exp_busy = 0;
  logic [39:0] m_btc = '0;
  logic [4:0]  m_mt  = '0;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Output monitor: record every pulse with its cycle
  always @(negedge clk) begin
    if (bus.rx_busy) busy_cnt++;
    if (bus.msg_ok && bus.msg_err) both_cnt++;
    if (bus.q_rdy)     obs_q.push_back(ev_t'{cyc, 0, {32'd0, bus.q}, bus.msg_type, bus.btc});
    if (bus.msg_start) obs_q.push_back(ev_t'{cyc, 1, 40'd0, bus.msg_type, bus.btc});
    if (bus.msg_ok)    obs_q.push_back(ev_t'{cyc, 2, 40'd0, bus.msg_type, bus.btc});
    if (bus.msg_err)   obs_q.push_back(ev_t'{cyc, 3, {38'd0, bus.err_code}, bus.msg_type, bus.btc});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic int type_len(input logic [7:0] b);
    case (b)
      8'hA1:        return TM_LEN;
      8'hA2:        return 5;
      8'hA3, 8'hA4: return 0;
      8'hA5:        return CCW_LEN;
      default:      return -1;
    endcase
  endfunction

  function automatic bq_t make_frame(input logic [7:0] ty, input bq_t pl, input bit corrupt);
    bq_t fr;
    logic [15:0] c;
    c = crc_upd(16'hFFFF, ty);
    fr.push_back(ty);
    foreach (pl[i]) begin
      c = crc_upd(c, pl[i]);
      fr.push_back(pl[i]);
    end
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0] ^ (corrupt ? 8'h01 : 8'h00));
    return fr;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t pl;
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    return pl;
  endfunction

  // One clock of stimulus; accepted bytes are logged with their cycle
  task automatic drive(input logic v, input logic [7:0] b);
    bus.d_rdy = v;
    bus.d     = b;
    if (v) stream.push_back(sb_t'{b, cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  task automatic send(input bq_t bs, input int max_gap);
    foreach (bs[i]) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      drive(1'b1, bs[i]);
    end
  endtask

  // Frame-level reference: walk the logged byte stream and list the events
  task automatic run_model();
    int i, n, len, k, c, last;
    logic [15:0] crc, rx_crc;
    logic [39:0] sh;
    bit tout;
    exp_q.delete();
    exp_busy = 0;
    n = stream.size();
    i = 0;
    while (i < n) begin
      c   = stream[i].cyc;
      len = type_len(stream[i].b);
      if (len < 0) begin
        exp_q.push_back(ev_t'{c + 1, 3, 40'd1, m_mt, m_btc});
        i++;
        continue;
      end
      m_mt = 5'b00001 << (stream[i].b - 8'hA1);
      exp_q.push_back(ev_t'{c + 1, 1, 40'd0, m_mt, m_btc});
      crc    = crc_upd(16'hFFFF, stream[i].b);
      rx_crc = '0;
      sh     = '0;
      last   = c;
      tout   = 1'b0;
      for (k = 1; k <= len + 2; k++) begin
        if (i + k >= n || stream[i + k].cyc - last >= GAP) begin
          exp_q.push_back(ev_t'{last + GAP, 3, 40'd3, m_mt, m_btc});
          exp_busy += last + GAP - 1 - c;
          tout = 1'b1;
          break;
        end
        last = stream[i + k].cyc;
        if (k <= len) begin
          crc = crc_upd(crc, stream[i + k].b);
          sh  = {sh[31:0], stream[i + k].b};
          exp_q.push_back(ev_t'{last + 1, 0, {32'd0, stream[i + k].b}, m_mt, m_btc});
        end else begin
          rx_crc = {rx_crc[7:0], stream[i + k].b};
        end
      end
      if (tout) begin
        i += k;
      end else begin
        if (rx_crc == crc) begin
          if (m_mt == 5'b00010) m_btc = sh;
          exp_q.push_back(ev_t'{last + 1, 2, 40'd0, m_mt, m_btc});
        end else begin
          exp_q.push_back(ev_t'{last + 1, 3, 40'd2, m_mt, m_btc});
        end
        exp_busy += last - c;
        i += len + 3;
      end
    end
  endtask

  task automatic begin_scn();
    obs_q.delete();
    stream.delete();
    busy_cnt = 0;
    both_cnt = 0;
  endtask

  task automatic compare(input string tag);
    int m;
    run_model();
    check_eq({tag, "_nev"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_eq($sformatf("%s_ev%0d_cyc", tag, i),  obs_q[i].cyc,  exp_q[i].cyc);
      check_eq($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check_eq($sformatf("%s_ev%0d_val", tag, i),  obs_q[i].val,  exp_q[i].val);
      check_eq($sformatf("%s_ev%0d_type", tag, i), obs_q[i].mt,   exp_q[i].mt);
      check_eq($sformatf("%s_ev%0d_btc", tag, i),  obs_q[i].btc,  exp_q[i].btc);
    end
    check_eq({tag, "_busy"}, busy_cnt, exp_busy);
    check_eq({tag, "_okerr_excl"}, both_cnt, 0);
  endtask

  function automatic int count_kind(input int kind);
    int n;
    n = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == kind) n++;
    return n;
  endfunction

  initial begin
    bq_t fr, fr2, pl;
    int  p;
    logic [7:0] b;

    bus.d     = '0;
    bus.d_rdy = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_q",        bus.q,         0);
    check_eq("rst_q_rdy",    bus.q_rdy,     0);
    check_eq("rst_msg_type", bus.msg_type,  0);
    check_eq("rst_start",    bus.msg_start, 0);
    check_eq("rst_ok",       bus.msg_ok,    0);
    check_eq("rst_err",      bus.msg_err,   0);
    check_eq("rst_err_code", bus.err_code,  0);
    check_eq("rst_btc",      bus.btc,       0);
    check_eq("rst_busy",     bus.rx_busy,   0);
    rst = 1'b0;

    // SR frame, no payload
    begin_scn();
    pl.delete();
    send(make_frame(8'hA3, pl, 1'b0), 0);
    idle(8);
    check_eq("sr_type", bus.msg_type, 5'b00100);
    check_eq("sr_no_q", count_kind(0), 0);
    compare("sr");

    // BTC frame with known payload
    begin_scn();
    pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send(make_frame(8'hA2, pl, 1'b0), 1);
    idle(8);
    check_eq("btc_value", bus.btc, 40'h123456789A);
    compare("btc");

    // Same BTC frame with a damaged CRC low byte
    begin_scn();
    send(make_frame(8'hA2, pl, 1'b1), 0);
    idle(8);
    check_eq("btc_bad_code", bus.err_code, 2);
    check_eq("btc_bad_keep", bus.btc, 40'h123456789A);
    compare("btc_bad");

    // Unknown type byte in IDLE
    begin_scn();
    drive(1'b1, 8'h55);
    idle(6);
    check_eq("unk_code", bus.err_code, 1);
    compare("unk");

    // TM frame abandoned after 10 payload bytes
    begin_scn();
    fr = make_frame(8'hA1, rand_payload(TM_LEN), 1'b0);
    fr = fr[0:10];
    send(fr, 0);
    p = stream[stream.size() - 1].cyc;
    idle(GAP + 8);
    check_eq("gap_code", bus.err_code, 3);
    check_eq("gap_latency", (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].cyc - p : -1, GAP);
    compare("gap");

    // TM frame whose 11th payload byte arrives on the expiry cycle
    begin_scn();
    fr  = make_frame(8'hA1, rand_payload(TM_LEN), 1'b0);
    fr2 = fr[11:$];
    fr  = fr[0:10];
    send(fr, 0);
    idle(GAP - 2);
    send(fr2, 0);
    idle(8);
    check_eq("gap_edge_ok", count_kind(2), 1);
    check_eq("gap_edge_err", count_kind(3), 0);
    compare("gap_edge");

    // Reset in the middle of a CCW frame, then a DPR frame
    begin_scn();
    fr = make_frame(8'hA5, rand_payload(CCW_LEN), 1'b0);
    send(fr[0:2], 0);
    rst = 1'b1;
    bus.d_rdy = 1'b1;
    bus.d = 8'($urandom);
    @(posedge clk);
    #1;
    obs_q.delete();
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      bus.d = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.d_rdy = 1'b0;
    idle(3);
    check_eq("rst_mid_pulses", obs_q.size(), 0);
    check_eq("rst_mid_busy", busy_cnt, 0);
    check_eq("rst_mid_btc", bus.btc, 0);
    check_eq("rst_mid_type", bus.msg_type, 0);
    m_btc = '0;
    m_mt  = '0;
    begin_scn();
    pl.delete();
    send(make_frame(8'hA4, pl, 1'b0), 2);
    idle(8);
    compare("dpr");

    // Two TM frames with d_rdy held high throughout
    begin_scn();
    fr  = make_frame(8'hA1, rand_payload(TM_LEN), 1'b0);
    fr2 = make_frame(8'hA1, rand_payload(TM_LEN), 1'b0);
    send({fr, fr2}, 0);
    idle(8);
    check_eq("b2b_ok_count", count_kind(2), 2);
    compare("b2b");

    // Random mix of frames, bad CRCs and unknown bytes
    begin_scn();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = 8'($urandom);
        while (b >= 8'hA1 && b <= 8'hA5) b = 8'($urandom);
        fr.delete();
        fr.push_back(b);
      end else begin
        b  = 8'hA1 + 8'($urandom_range(0, 4));
        fr = make_frame(b, rand_payload(type_len(b)), $urandom_range(0, 5) == 0);
      end
      send(fr, 3);
    end
    idle(8);
    compare("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
